// File: rtl/orv32_div.sv
// RV32M iterative divider: DIV/DIVU/REM/REMU, restoring radix-2, one quotient bit per cycle.
// Optional macro ORV32_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip straight to DONE.
module orv32_div #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [2:0]       funct3_i,
   input  logic [31:0]      rs1_i,
   input  logic [31:0]      rs2_i,
   input  logic [TAG_W-1:0] rd_i,
   input  logic             kill_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [31:0]      result_o,
   output logic [TAG_W-1:0] rd_o
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           r_state;
   logic [4:0]       r_cnt;
   logic [31:0]      r_quo;
   logic [31:0]      r_rem;
   logic [31:0]      r_dvs;
   logic             r_rem_sel;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_div0;
   logic             r_valid;
   logic [31:0]      r_result;
   logic [TAG_W-1:0] r_rd;

   logic        w_uns, w_neg1, w_neg2, w_div0_in;
   logic [31:0] w_mag1, w_mag2;
   logic [32:0] w_rem_sh, w_diff;
   logic        w_ge;
   logic [31:0] w_rem_nx, w_quo_nx, w_q_fix, w_r_fix, w_final;
   logic        w_unused;

   // funct3[2] only distinguishes MUL from DIV upstream
   assign w_unused  = funct3_i[2];

   assign w_uns     = funct3_i[0];
   assign w_neg1    = !w_uns && rs1_i[31];
   assign w_neg2    = !w_uns && rs2_i[31];
   assign w_mag1    = w_neg1 ? -rs1_i : rs1_i;
   assign w_mag2    = w_neg2 ? -rs2_i : rs2_i;
   assign w_div0_in = (rs2_i == 32'h0);

   // One restoring step: shift in the next dividend bit, keep the trial difference if non-negative
   assign w_rem_sh  = {r_rem, r_quo[31]};
   assign w_diff    = w_rem_sh - {1'b0, r_dvs};
   assign w_ge      = !w_diff[32];
   assign w_rem_nx  = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
   assign w_quo_nx  = {r_quo[30:0], w_ge};

   // Signed overflow falls out naturally (|q| = 2^31, positive sign); only a zero divisor needs an override
   assign w_q_fix   = r_neg_q ? -w_quo_nx : w_quo_nx;
   assign w_r_fix   = r_neg_r ? -w_rem_nx : w_rem_nx;
   assign w_final   = r_rem_sel ? w_r_fix : (r_div0 ? 32'hFFFF_FFFF : w_q_fix);

`ifdef ORV32_DIV_EARLY_OUT_EN
   logic        w_ovf_in;
   logic [31:0] w_early;
   assign w_ovf_in = !w_uns && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
   assign w_early  = funct3_i[1] ? (w_div0_in ? rs1_i : 32'h0)
                                 : (w_div0_in ? 32'hFFFF_FFFF : 32'h8000_0000);
`endif

   assign req_ready_o  = (r_state == IDLE) && !kill_i && !rst;
   assign resp_valid_o = r_valid;
   assign result_o     = r_result;
   assign rd_o         = r_rd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= 5'd0;
         r_quo     <= 32'h0;
         r_rem     <= 32'h0;
         r_dvs     <= 32'h0;
         r_rem_sel <= 1'b0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_div0    <= 1'b0;
         r_valid   <= 1'b0;
         r_result  <= 32'h0;
         r_rd      <= '0;
      end else if (kill_i) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid_i) begin
                  r_quo     <= w_mag1;
                  r_rem     <= 32'h0;
                  r_dvs     <= w_mag2;
                  r_cnt     <= 5'd0;
                  r_rem_sel <= funct3_i[1];
                  r_neg_q   <= w_neg1 ^ w_neg2;
                  r_neg_r   <= w_neg1;
                  r_div0    <= w_div0_in;
                  r_rd      <= rd_i;
`ifdef ORV32_DIV_EARLY_OUT_EN
                  if (w_div0_in || w_ovf_in) begin
                     r_state  <= DONE;
                     r_valid  <= 1'b1;
                     r_result <= w_early;
                  end else begin
                     r_state  <= CALC;
                  end
`else
                  r_state   <= CALC;
`endif
               end
            end
            CALC: begin
               r_quo <= w_quo_nx;
               r_rem <= w_rem_nx;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) begin
                  r_state  <= DONE;
                  r_valid  <= 1'b1;
                  r_result <= w_final;
               end
            end
            DONE: begin
               if (resp_ready_i) begin
                  r_state <= IDLE;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_orv32_div.sv
// Self-checking bench for orv32_div: directed corner cases plus randomized ops against an arithmetic model.
module tb_orv32_div;
   localparam int TAG_W = 5;
`ifdef ORV32_DIV_EARLY_OUT_EN
   localparam int SPECIAL_LAT = 1;
`else
   localparam int SPECIAL_LAT = 33;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid_i;
   logic             req_ready_o;
   logic [2:0]       funct3_i;
   logic [31:0]      rs1_i;
   logic [31:0]      rs2_i;
   logic [TAG_W-1:0] rd_i;
   logic             kill_i;
   logic             resp_valid_o;
   logic             resp_ready_i;
   logic [31:0]      result_o;
   logic [TAG_W-1:0] rd_o;

   int errors = 0;
   int checks = 0;

   orv32_div #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
      .kill_i(kill_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .result_o(result_o), .rd_o(rd_o)
   );

   always #5 clk = ~clk;

   // RV32M semantics straight from the ISA rules
   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
      if (f3[0]) return f3[1] ? (a % b) : (a / b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
      return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'h0) return SPECIAL_LAT;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SPECIAL_LAT;
      return 33;
   endfunction

   // Issue one op and wait for its response; lat counts edges from the accept edge (inclusive)
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, output bit ok, output int lat,
                         output logic [31:0] res, output logic [TAG_W-1:0] tag_o);
      int n;
      @(negedge clk);
      req_valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = tag;
      n = 0;
      while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
      ok = req_ready_o;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      lat = 1;
      while (!resp_valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
      ok = ok && resp_valid_o;
      res = result_o;
      tag_o = rd_o;
   endtask

   task automatic watch_no_resp(input int cycles, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (resp_valid_o) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid_i = 1'b0; kill_i = 1'b0; resp_ready_i = 1'b1;
      funct3_i = 3'b0; rs1_i = 32'h0; rs2_i = 32'h0; rd_i = '0;
      #3;
      checks++;
      if ({resp_valid_o, req_ready_o, result_o, rd_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b ready=%b result=%h rd=%h, want all 0",
                  resp_valid_o, req_ready_o, result_o, rd_o);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ready=%b valid=%b, want ready=1 valid=0", req_ready_o, resp_valid_o);
      end
   endtask

   task automatic test_basic();
      logic [2:0]  f3 [2] = '{3'b101, 3'b111};
      logic [31:0] e  [2] = '{32'd14, 32'd2};
      bit ok; int lat; logic [31:0] res; logic [TAG_W-1:0] tg;
      for (int i = 0; i < 2; i++) begin
         run_op(f3[i], 32'd100, 32'd7, TAG_W'(i + 1), ok, lat, res, tg);
         checks++;
         if (!ok || res !== e[i] || tg !== TAG_W'(i + 1) || lat != 33) begin
            errors++;
            $display("FAIL basic[%0d]: ok=%0b res=%h rd=%0d lat=%0d, want res=%h rd=%0d lat=33",
                     i, ok, res, tg, lat, e[i], i + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok; int lat; logic [31:0] res; logic [TAG_W-1:0] tg;
      resp_ready_i = 1'b1;
      run_op(3'b101, 32'd1000, 32'd3, 5'd11, ok, lat, res, tg);
      checks++;
      if (!ok || res !== 32'd333 || req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done: ok=%0b res=%h ready=%b, want res=0000014d ready=0", ok, res, req_ready_o);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_bubble: valid=%b ready=%b, want valid=0 ready=1", resp_valid_o, req_ready_o);
      end
      run_op(3'b111, 32'd1000, 32'd3, 5'd12, ok, lat, res, tg);
      checks++;
      if (!ok || res !== 32'd1 || tg !== 5'd12 || lat != 33) begin
         errors++;
         $display("FAIL b2b_second: ok=%0b res=%h rd=%0d lat=%0d, want res=1 rd=12 lat=33", ok, res, tg, lat);
      end
   endtask

   task automatic test_signed();
      logic [2:0]  f3 [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
      logic [31:0] a  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
      logic [31:0] b  [4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
      logic [31:0] e  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1};
      bit ok; int lat; logic [31:0] res; logic [TAG_W-1:0] tg;
      for (int i = 0; i < 4; i++) begin
         run_op(f3[i], a[i], b[i], TAG_W'(i + 3), ok, lat, res, tg);
         checks++;
         if (!ok || res !== e[i] || tg !== TAG_W'(i + 3) || lat != 33) begin
            errors++;
            $display("FAIL signed[%0d]: ok=%0b res=%h rd=%0d lat=%0d, want res=%h rd=%0d lat=33",
                     i, ok, res, tg, lat, e[i], i + 3);
         end
      end
   endtask

   task automatic test_special();
      logic [2:0]  f3 [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
      logic [31:0] a  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] e  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      bit ok; int lat; logic [31:0] res; logic [TAG_W-1:0] tg;
      for (int i = 0; i < 4; i++) begin
         run_op(f3[i], a[i], b[i], TAG_W'(i + 20), ok, lat, res, tg);
         checks++;
         if (!ok || res !== e[i] || tg !== TAG_W'(i + 20) || lat != SPECIAL_LAT) begin
            errors++;
            $display("FAIL special[%0d]: ok=%0b res=%h rd=%0d lat=%0d, want res=%h rd=%0d lat=%0d",
                     i, ok, res, tg, lat, e[i], i + 20, SPECIAL_LAT);
         end
      end
   endtask

   task automatic test_random();
      bit ok; int lat; logic [31:0] res; logic [TAG_W-1:0] tg;
      logic [2:0] f3; logic [31:0] a, b; logic [TAG_W-1:0] tag;
      for (int i = 0; i < 24; i++) begin
         f3 = 3'($urandom); a = $urandom; tag = TAG_W'($urandom);
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 15);
            3: b = 32'($urandom_range(0, 3)) - 32'd2;
            default: b = $urandom;
         endcase
         run_op(f3, a, b, tag, ok, lat, res, tg);
         checks++;
         if (!ok || res !== ref_result(f3, a, b) || tg !== tag || lat != ref_latency(f3, a, b)) begin
            errors++;
            $display("FAIL random[%0d] f3=%b a=%h b=%h: ok=%0b res=%h rd=%0d lat=%0d, want res=%h rd=%0d lat=%0d",
                     i, f3, a, b, ok, res, tg, lat, ref_result(f3, a, b), tag, ref_latency(f3, a, b));
         end
      end
   endtask

   task automatic test_kill();
      bit ok, seen; int lat; logic [31:0] res; logic [TAG_W-1:0] tg;
      resp_ready_i = 1'b1;
      // kill in CALC cycle 10
      @(negedge clk);
      req_valid_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd77777; rs2_i = 32'd3; rd_i = 5'd30;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); kill_i = 1'b1;
      @(posedge clk); #1; kill_i = 1'b0; #1;
      checks++;
      if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL kill_calc_ready: ready=%b valid=%b, want ready=1 valid=0", req_ready_o, resp_valid_o);
      end
      watch_no_resp(40, seen);
      checks++;
      if (seen) begin errors++; $display("FAIL kill_calc_noresp: resp_valid seen=1, want 0"); end
      run_op(3'b101, 32'd9, 32'd3, 5'd17, ok, lat, res, tg);
      checks++;
      if (!ok || res !== 32'd3 || tg !== 5'd17 || lat != 33) begin
         errors++;
         $display("FAIL kill_after_op: ok=%0b res=%h rd=%0d lat=%0d, want res=3 rd=17 lat=33", ok, res, tg, lat);
      end
      // kill and request together in IDLE: request is dropped
      @(negedge clk);
      req_valid_i = 1'b1; kill_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd50; rs2_i = 32'd5; rd_i = 5'd2;
      #1;
      checks++;
      if (req_ready_o !== 1'b0) begin errors++; $display("FAIL kill_idle_ready: ready=%b, want 0", req_ready_o); end
      @(posedge clk); #1;
      req_valid_i = 1'b0; kill_i = 1'b0;
      watch_no_resp(40, seen);
      checks++;
      if (seen) begin errors++; $display("FAIL kill_idle_noresp: resp_valid seen=1, want 0"); end
      // kill in DONE together with resp_ready: result is discarded
      resp_ready_i = 1'b0;
      run_op(3'b100, 32'd40, 32'd8, 5'd6, ok, lat, res, tg);
      @(negedge clk); kill_i = 1'b1; resp_ready_i = 1'b1;
      @(posedge clk); #1; kill_i = 1'b0;
      checks++;
      if (!ok || res !== 32'd5 || resp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL kill_done: ok=%0b res=%h valid=%b, want res=5 valid=0", ok, res, resp_valid_o);
      end
   endtask

   task automatic test_backpressure();
      bit ok; int lat; logic [31:0] res; logic [TAG_W-1:0] tg;
      resp_ready_i = 1'b0;
      run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd10, ok, lat, res, tg);
      checks++;
      if (!ok || res !== 32'hFFFF_FFF2 || tg !== 5'd10) begin
         errors++;
         $display("FAIL bp_result: ok=%0b res=%h rd=%0d, want res=fffffff2 rd=10", ok, res, tg);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (resp_valid_o !== 1'b1 || result_o !== res || rd_o !== tg) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b res=%h rd=%0d, want valid=1 res=%h rd=%0d",
                     i, resp_valid_o, result_o, rd_o, res, tg);
         end
      end
      @(negedge clk); resp_ready_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: valid=%b ready=%b, want valid=0 ready=1", resp_valid_o, req_ready_o);
      end
   endtask

   task automatic test_async_reset();
      bit ok, seen; int lat; logic [31:0] res; logic [TAG_W-1:0] tg;
      resp_ready_i = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd1000; rs2_i = 32'd10; rd_i = 5'd7;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({resp_valid_o, req_ready_o, result_o, rd_o} !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b ready=%b result=%h rd=%h, want all 0",
                  resp_valid_o, req_ready_o, result_o, rd_o);
      end
      @(negedge clk); rst = 1'b0;
      watch_no_resp(40, seen);
      checks++;
      if (seen) begin errors++; $display("FAIL async_reset_noresp: resp_valid seen=1, want 0"); end
      run_op(3'b111, 32'd1000, 32'd7, 5'd9, ok, lat, res, tg);
      checks++;
      if (!ok || res !== 32'd6 || tg !== 5'd9 || lat != 33) begin
         errors++;
         $display("FAIL async_reset_next: ok=%0b res=%h rd=%0d lat=%0d, want res=6 rd=9 lat=33", ok, res, tg, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_signed();
      test_special();
      test_random();
      test_kill();
      test_backpressure();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/orv32_div.md
ORV32_DIV -- requirements
Module: orv32_div

Interface
REQ-001 SHALL have parameter TAG_W, default 5, giving the destination-register tag width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid_i, input, 1 bit: a divide request is present.
REQ-005 SHALL have port req_ready_o, output, 1 bit: the unit can accept a request.
REQ-006 SHALL have port funct3_i, input, 3 bits: RV32M funct3 (DIV 100, DIVU 101, REM 110, REMU 111).
REQ-007 SHALL have port rs1_i, input, 32 bits: dividend.
REQ-008 SHALL have port rs2_i, input, 32 bits: divisor.
REQ-009 SHALL have port rd_i, input, TAG_W bits: destination tag.
REQ-010 SHALL have port kill_i, input, 1 bit: pipeline flush.
REQ-011 SHALL have port resp_valid_o, output, 1 bit: result is valid.
REQ-012 SHALL have port resp_ready_i, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port result_o, output, 32 bits: quotient or remainder.
REQ-014 SHALL have port rd_o, output, TAG_W bits: tag of the result.

Function
REQ-015 SHALL implement states IDLE, CALC and DONE.
REQ-016 SHALL drive req_ready_o = (state==IDLE) && !kill_i && !rst.
REQ-017 SHALL accept a request on a clock edge with req_valid_i && req_ready_o, latching funct3_i, rs1_i, rs2_i and rd_i.
REQ-018 SHALL decode funct3_i[1] as remainder-select and funct3_i[0] as unsigned-select; funct3_i[2] is ignored.
REQ-019 SHALL take the operand magnitudes for signed ops, then run a restoring radix-2 division at one quotient bit per cycle for exactly 32 CALC cycles, counted by a 5-bit counter.
REQ-020 SHALL give a signed quotient the sign rs1^rs2, and a signed remainder the sign of rs1.
REQ-021 SHALL, for a divisor of 0, return quotient 0xFFFFFFFF and remainder = rs1.
REQ-022 SHALL, for DIV/REM with 0x80000000 / 0xFFFFFFFF, return quotient 0x80000000 and remainder 0.
REQ-023 SHALL make the result and rd_o valid in DONE, with resp_valid_o high exactly in DONE, which is 33 cycles after the accept edge (default latency).
REQ-024 SHALL hold result_o and rd_o stable while resp_valid_o && !resp_ready_i.
REQ-025 SHALL move DONE->IDLE on resp_valid_o && resp_ready_i, so back-to-back ops have a one-cycle bubble.
REQ-026 SHALL, when kill_i is high in any state, enter IDLE on the next edge, discard the operation, and never raise resp_valid_o for it.
REQ-027 SHALL, when kill_i and req_valid_i are high together, not accept the request, because kill takes priority.
REQ-028 SHALL, when kill_i arrives in DONE in the same cycle as resp_ready_i, treat the result as killed.

Reset
REQ-029 SHALL, while rst is high, force state IDLE, counter 0, and resp_valid_o, req_ready_o, result_o and rd_o to 0, without waiting for clk.
REQ-030 SHALL, on a reset asserted mid-CALC or in DONE, abandon the operation and raise no response after release.

Configuration
REQ-031 SHALL, when macro ORV32_DIV_EARLY_OUT_EN is defined, complete divide-by-zero and signed-overflow cases by going from IDLE straight to DONE, so resp_valid_o rises 1 cycle after accept.
REQ-032 SHALL, without ORV32_DIV_EARLY_OUT_EN, give all cases the 33-cycle latency; result values SHALL be identical in both builds.

Verification
REQ-033 SHALL cover DIVU 100/7, then REMU 100/7 -> 14, then 2; resp_valid_o rises exactly 33 cycles after accept.
REQ-034 SHALL cover signed sign rules: DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, DIV 7/-2 -> 0xFFFFFFFD, REM 7/-2 -> 1.
REQ-035 SHALL cover special cases: DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of the same -> 0; latency 1 with ORV32_DIV_EARLY_OUT_EN, 33 without.
REQ-036 SHALL cover kill_i pulsed at CALC cycle 10 -> no resp_valid_o, req_ready_o high the next cycle; a following DIVU 9/3 -> 3 with correct rd_o.
REQ-037 SHALL cover resp_ready_i held low 5 cycles in DONE -> result_o and rd_o stable; accept on cycle 6 -> IDLE next cycle.
REQ-038 SHALL cover rst asserted asynchronously mid-CALC -> outputs 0 immediately, no response after release, and the next op correct.
